rvfi_commit_sequencer: RTL

//  Shares the single RVFI monitor interface between NUM_LANES retire lanes that may commit out of order.

---
 rtl/rvfi_seq_pkg.sv | 29 ++
 rtl/rvfi_reorder_buf.sv | 53 +++++
 rtl/rvfi_commit_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/rvfi_seq_pkg.sv
// Shared types for the RVFI commit sequencer: the commit packet layout that
// mirrors the monitor interface fields, and the sticky error codes.
package rvfi_seq_pkg;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_pkt_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_STALE   = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_t;

endpackage

// File: rtl/rvfi_reorder_buf.sv
// Reorder window storage: DEPTH packet slots with per-slot valid bits.
// One write port per retire lane, one read/clear port at the expected order.
// The lane arbitration upstream guarantees no two lanes write the same slot
// in one cycle, and a slot being cleared is never written in that cycle.
module rvfi_reorder_buf
  import rvfi_seq_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_LANES-1:0]                      i_wr_en,
  input  logic [NUM_LANES-1:0][$clog2(DEPTH)-1:0]   i_wr_idx,
  input  rvfi_pkt_t [NUM_LANES-1:0]                 i_wr_pkt,
  input  logic [$clog2(DEPTH)-1:0]                  i_rd_idx,
  input  logic                                      i_rd_clr,
  output rvfi_pkt_t                                 o_rd_pkt,
  output logic [DEPTH-1:0]                          o_valid
);

  rvfi_pkt_t        r_pkt [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;

  // Decode per-lane writes and the drain clear into slot masks.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (i_wr_en[l]) w_set[i_wr_idx[l]] = 1'b1;
    end
    if (i_rd_clr) w_clr[i_rd_idx] = 1'b1;
  end

  // Slot valid bits; reset empties the whole window at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_valid <= '0;
    else        r_valid <= (r_valid & ~w_clr) | w_set;
  end

  // Packet payload storage; contents are only meaningful under a valid bit.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (i_wr_en[l]) r_pkt[i_wr_idx[l]] <= i_wr_pkt[l];
    end
  end

  assign o_rd_pkt = r_pkt[i_rd_idx];
  assign o_valid  = r_valid;

endmodule

// File: rtl/rvfi_commit_sequencer.sv
// Funnels NUM_LANES out-of-order retire lanes onto one RVFI monitor port.
// Packets are tagged by order; they are parked in a reorder window indexed by
// order[log2(DEPTH)-1:0] and emitted one per cycle in strictly increasing order.
//
// Handshake: a lane packet transfers on a cycle where in_valid[i] && in_ready[i]
// at the rising edge. in_ready is combinational and may depend on in_valid of
// lower-index lanes (slot collision priority). The output side has no
// back-pressure: out_valid is a one-cycle pulse per emitted packet.
module rvfi_commit_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_LANES-1:0]       in_valid,
  output logic [NUM_LANES-1:0]       in_ready,
  input  rvfi_pkt_t [NUM_LANES-1:0]  in_pkt,
  output logic                       out_valid,
  output rvfi_pkt_t                  out_pkt,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       err,
  output err_code_t                  err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [63:0]                   r_exp_order;
  logic                          r_out_valid;
  rvfi_pkt_t                     r_out_pkt;
  logic [OW-1:0]                 r_occ;
  logic [TW-1:0]                 r_to_cnt;
  logic                          r_err;
  err_code_t                     r_err_code;

  logic [AW-1:0]                 w_exp_slot;
  logic [NUM_LANES-1:0][AW-1:0]  w_slot;
  logic [NUM_LANES-1:0]          w_stale;
  logic [NUM_LANES-1:0]          w_in_win;
  logic [NUM_LANES-1:0]          w_conflict;
  logic [NUM_LANES-1:0]          w_acc;
  logic [NUM_LANES-1:0]          w_byp;
  logic [NUM_LANES-1:0]          w_wr_en;
  logic [DEPTH-1:0]              w_buf_valid;
  rvfi_pkt_t                     w_buf_pkt;
  rvfi_pkt_t                     w_byp_pkt;
  logic                          w_buf_hit;
  logic                          w_drain;
  logic                          w_stale_hit;
  logic                          w_to_inc;
  logic                          w_to_hit;
  logic [OW-1:0]                 w_n_wr;

  rvfi_reorder_buf #(
    .NUM_LANES (NUM_LANES),
    .DEPTH     (DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (w_slot),
    .i_wr_pkt (in_pkt),
    .i_rd_idx (w_exp_slot),
    .i_rd_clr (w_buf_hit),
    .o_rd_pkt (w_buf_pkt),
    .o_valid  (w_buf_valid)
  );

  // Classify each lane against the window and resolve slot collisions by lane index.
  always_comb begin
    w_exp_slot = r_exp_order[AW-1:0];
    w_slot     = '0;
    w_stale    = '0;
    w_in_win   = '0;
    w_conflict = '0;
    in_ready   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_slot[i]   = in_pkt[i].order[AW-1:0];
      w_stale[i]  = in_pkt[i].order < r_exp_order;
      // Unsigned distance from exp_order; stale packets are excluded first.
      w_in_win[i] = !w_stale[i] && ((in_pkt[i].order - r_exp_order) < 64'(DEPTH));
      for (int j = 0; j < i; j++) begin
        if (in_valid[j] && (w_slot[j] == w_slot[i])) w_conflict[i] = 1'b1;
      end
      in_ready[i] = w_stale[i] |
                    (w_in_win[i] & ~w_buf_valid[w_slot[i]] & ~w_conflict[i]);
    end
  end

  // Route accepted packets: bypass the expected one, park the rest, count writes.
  always_comb begin
    w_acc     = in_valid & in_ready;
    w_byp     = '0;
    w_wr_en   = '0;
    w_byp_pkt = '0;
    w_n_wr    = '0;
    w_buf_hit = w_buf_valid[w_exp_slot];
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_acc[i] && !w_stale[i]) begin
        // A valid expected slot blocks acceptance of its order, so bypass
        // and buffered drain never coincide.
        if (in_pkt[i].order == r_exp_order) begin
          w_byp[i]  = 1'b1;
          w_byp_pkt = in_pkt[i];
        end else begin
          w_wr_en[i] = 1'b1;
          w_n_wr     = w_n_wr + OW'(1);
        end
      end
    end
    w_drain     = w_buf_hit | (|w_byp);
    w_stale_hit = |(w_acc & w_stale);
    w_to_inc    = (r_occ != '0) && !w_drain;
    w_to_hit    = w_to_inc && (r_to_cnt == TW'(TIMEOUT - 1));
  end

  // Emit one packet per cycle in order and track the expected order and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_order <= '0;
      r_out_valid <= 1'b0;
      r_out_pkt   <= '0;
      r_occ       <= '0;
    end else begin
      r_out_valid <= w_drain;
      if (w_drain) begin
        r_out_pkt   <= w_buf_hit ? w_buf_pkt : w_byp_pkt;
        r_exp_order <= r_exp_order + 64'd1;
      end
      r_occ <= r_occ + w_n_wr - OW'(w_buf_hit);
    end
  end

  // Stall watchdog and sticky first-error capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt   <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      if (!w_to_inc)                         r_to_cnt <= '0;
      else if (r_to_cnt != TW'(TIMEOUT))     r_to_cnt <= r_to_cnt + TW'(1);
      if (w_stale_hit || w_to_hit) r_err <= 1'b1;
      if (r_err_code == ERR_NONE) begin
        if (w_stale_hit)   r_err_code <= ERR_STALE;
        else if (w_to_hit) r_err_code <= ERR_TIMEOUT;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_pkt   = r_out_pkt;
  assign occupancy = r_occ;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule
